// File: rtl/commutator_route_ctrl.sv
// Route controller for the 8-to-3 commutator: a shadow table of select words,
// applied on commit (manual) or stepped through with a dwell time (scan).
module commutator_route_ctrl #(
  parameter int N_CFG   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(N_CFG)-1:0]   wr_slot,
  input  logic [1:0]                 wr_out,
  input  logic [2:0]                 wr_sel,
  input  logic                       commit,
  input  logic [$clog2(N_CFG)-1:0]   cfg_slot,
  input  logic                       scan_en,
  input  logic [DWELL_W-1:0]         dwell,
  output logic [8:0]                 control,
  output logic [$clog2(N_CFG)-1:0]   cur_slot,
  output logic                       busy,
  output logic                       err,
  output logic [1:0]                 fsm_state
);
  localparam int SW = $clog2(N_CFG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [8:0]         shadow [N_CFG];
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]      lat_q, lat_d;
  logic               start_q, start_d;
  logic               load_en;
  logic [SW-1:0]      load_slot;
  logic               wr_fire;

  // Write handshake: a write is taken at a rising edge where wr_valid and
  // wr_ready are both high; wr_ready drops only while a commit is in flight.
  assign wr_ready  = (state_q != COMMIT);
  assign wr_fire   = wr_valid & wr_ready;
  assign busy      = (state_q == COMMIT);
  assign fsm_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    start_d   = start_q;
    load_en   = 1'b0;
    load_slot = cur_slot;
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = SCAN;
          start_d = 1'b1;
        end else if (commit) begin
          state_d = COMMIT;
          lat_d   = cfg_slot;
        end
      end
      COMMIT: begin
        state_d   = IDLE;
        load_en   = 1'b1;
        load_slot = lat_q;
      end
      SCAN: begin
        if (!scan_en) begin
          state_d = IDLE;
          start_d = 1'b0;
        end else if (start_q) begin
          // First cycle in scan loads slot 0 and arms the dwell counter.
          load_en   = 1'b1;
          load_slot = '0;
          cnt_d     = dwell;
          start_d   = 1'b0;
        end else if (cnt_q == '0) begin
          load_en   = 1'b1;
          load_slot = cur_slot + SW'(1);
          cnt_d     = dwell;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      start_q  <= 1'b0;
      control  <= '0;
      cur_slot <= '0;
      err      <= 1'b0;
      for (int i = 0; i < N_CFG; i++) shadow[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      start_q <= start_d;
      if (load_en) begin
        control  <= shadow[load_slot];
        cur_slot <= load_slot;
      end
      // An illegal output index completes the handshake but only raises err.
      err <= wr_fire && (wr_out == 2'd3);
      if (wr_fire) begin
        case (wr_out)
          2'd0:    shadow[wr_slot][2:0] <= wr_sel;
          2'd1:    shadow[wr_slot][5:3] <= wr_sel;
          2'd2:    shadow[wr_slot][8:6] <= wr_sel;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_commutator_route_ctrl.sv
// Directed bench for commutator_route_ctrl: commit path, illegal writes,
// scan stepping and wrap, live rewrites during scan, and reset mid-scan.
module tb_commutator_route_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_slot;
  logic [1:0] wr_out;
  logic [2:0] wr_sel;
  logic       commit;
  logic [1:0] cfg_slot;
  logic       scan_en;
  logic [7:0] dwell;
  logic [8:0] control;
  logic [1:0] cur_slot;
  logic       busy;
  logic       err;
  logic [1:0] fsm_state;

  localparam logic [1:0] S_IDLE = 2'd0, S_COMMIT = 2'd1, S_SCAN = 2'd2;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] tbl [4];
  logic [8:0] old_val;

  commutator_route_ctrl #(.N_CFG(4), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_out(wr_out), .wr_sel(wr_sel), .commit(commit),
    .cfg_slot(cfg_slot), .scan_en(scan_en), .dwell(dwell), .control(control),
    .cur_slot(cur_slot), .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int slot, input int out, input int sel);
    wr_valid = 1'b1;
    wr_slot  = 2'(slot);
    wr_out   = 2'(out);
    wr_sel   = 3'(sel);
    tick();
    wr_valid = 1'b0;
    if (out < 3) tbl[slot][out*3 +: 3] = 3'(sel);
  endtask

  task automatic do_commit(input int slot);
    commit   = 1'b1;
    cfg_slot = 2'(slot);
    tick();
    commit = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_slot = '0; wr_out = '0; wr_sel = '0;
    commit = 1'b0; cfg_slot = '0; scan_en = 1'b0; dwell = '0;
    for (int i = 0; i < 4; i++) tbl[i] = '0;
    tick(); tick();
    check("rst_control", 32'(control), 32'd0);
    check("rst_cur_slot", 32'(cur_slot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    rst = 1'b0;

    // Manual commit of slot 1 = {7,2,5}
    wr(1, 0, 5); wr(1, 1, 2); wr(1, 2, 7);
    check("wr_no_err", 32'(err), 32'd0);
    commit = 1'b1; cfg_slot = 2'd1;
    tick();
    commit = 1'b0;
    check("commit_busy", 32'(busy), 32'd1);
    check("commit_ready_low", 32'(wr_ready), 32'd0);
    check("commit_ctrl_hold", 32'(control), 32'd0);
    tick();
    check("commit_ctrl", 32'(control), 32'h1D5);
    check("commit_cur_slot", 32'(cur_slot), 32'd1);
    check("commit_busy_done", 32'(busy), 32'd0);

    // Illegal write: err pulse, table untouched
    wr(1, 3, 0);
    check("illegal_err", 32'(err), 32'd1);
    tick();
    check("illegal_err_clr", 32'(err), 32'd0);
    do_commit(0);
    check("commit_slot0", 32'(control), 32'd0);
    do_commit(1);
    check("illegal_tbl_kept", 32'(control), 32'h1D5);

    // Write + commit same cycle; commit and write during COMMIT are refused
    wr_valid = 1'b1; wr_slot = 2'd2; wr_out = 2'd1; wr_sel = 3'd6;
    commit = 1'b1; cfg_slot = 2'd2;
    tick();
    tbl[2][5:3] = 3'd6;
    wr_slot = 2'd3; wr_out = 2'd0; wr_sel = 3'd4; cfg_slot = 2'd3;
    check("wc_ready_low", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    check("wc_ctrl", 32'(control), 32'h030);
    check("wc_cur_slot", 32'(cur_slot), 32'd2);
    check("wc_state_idle", 32'(fsm_state), 32'(S_IDLE));
    tick();
    check("wc_no_recommit", 32'(busy), 32'd0);
    do_commit(3);
    check("wc_slot3_unwritten", 32'(control), 32'd0);

    // Scan through distinct slots with dwell = 2
    for (int k = 0; k < 4; k++)
      for (int o = 0; o < 3; o++) wr(k, o, k + o + 1);
    dwell = 8'd2; scan_en = 1'b1;
    tick();
    check("scan_enter", 32'(fsm_state), 32'(S_SCAN));
    tick();
    for (int step = 0; step < 5; step++)
      for (int h = 0; h < 3; h++) begin
        check($sformatf("scan_ctrl_s%0d_h%0d", step, h), 32'(control), 32'(tbl[step % 4]));
        check($sformatf("scan_slot_s%0d_h%0d", step, h), 32'(cur_slot), 32'(step % 4));
        tick();
      end
    check("scan_wrap_slot1", 32'(cur_slot), 32'd1);

    // Rewrite active slot 1 during scan
    old_val = tbl[1];
    wr(1, 2, 0);
    check("live_wr_hold", 32'(control), 32'(old_val));
    tick();
    check("live_wr_hold2", 32'(control), 32'(old_val));
    repeat (9) tick();
    check("live_slot0", 32'(cur_slot), 32'd0);
    tick();
    check("live_new_val", 32'(control), 32'(tbl[1]));
    check("live_new_slot", 32'(cur_slot), 32'd1);

    // Reset mid-scan with dwell = 5, then restart
    dwell = 8'd5;
    tick(); tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tbl[i] = '0;
    check("mrst_control", 32'(control), 32'd0);
    check("mrst_cur_slot", 32'(cur_slot), 32'd0);
    check("mrst_state", 32'(fsm_state), 32'(S_IDLE));
    rst = 1'b0;
    tick();
    check("restart_state", 32'(fsm_state), 32'(S_SCAN));
    tick();
    check("restart_slot0", 32'(cur_slot), 32'd0);
    check("restart_ctrl0", 32'(control), 32'd0);
    wr(1, 0, 3);
    repeat (4) tick();
    check("dwell5_hold", 32'(cur_slot), 32'd0);
    tick();
    check("dwell5_adv_slot", 32'(cur_slot), 32'd1);
    check("dwell5_adv_ctrl", 32'(control), 32'(tbl[1]));
    scan_en = 1'b0;
    tick();
    check("scan_off_state", 32'(fsm_state), 32'(S_IDLE));
    check("scan_off_ctrl", 32'(control), 32'(tbl[1]));
    check("scan_off_slot", 32'(cur_slot), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
